// File: rtl/alu_arbiter_if.sv
//------------------------------------------------------------------------------
// alu_arbiter_if
//
// Purpose: groups the request and response handshake buses of the two-port
// ALU arbiter. Port i of every two-bit vector belongs to requester i.
// Multi-bit per-port fields are packed as {port1, port0}.
//
// Signals:
//   req_valid [1:0]   request valid, one bit per port          (master -> slave)
//   req_ready [1:0]   request accepted this cycle, per port    (slave  -> master)
//   req_op    [7:0]   {op1, op0}, 4-bit ALU op code per port   (master -> slave)
//   req_a     [63:0]  {a1, a0}, operand A per port             (master -> slave)
//   req_b     [63:0]  {b1, b0}, operand B per port             (master -> slave)
//   rsp_valid [1:0]   result valid for port i                  (slave  -> master)
//   rsp_ready [1:0]   port i takes the result                  (master -> slave)
//   rsp_data  [31:0]  result, shared by both ports             (slave  -> master)
//   rsp_err           op code of the result was illegal        (slave  -> master)
//
// Modports:
//   master : the requester side (drives requests, takes responses)
//   slave  : the arbiter side
//------------------------------------------------------------------------------
interface alu_arbiter_if;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [7:0]  req_op;
    logic [63:0] req_a;
    logic [63:0] req_b;
    logic [1:0]  rsp_valid;
    logic [1:0]  rsp_ready;
    logic [31:0] rsp_data;
    logic        rsp_err;

    modport master (
        output req_valid,
        input  req_ready,
        output req_op,
        output req_a,
        output req_b,
        input  rsp_valid,
        output rsp_ready,
        input  rsp_data,
        input  rsp_err
    );

    modport slave (
        input  req_valid,
        output req_ready,
        input  req_op,
        input  req_a,
        input  req_b,
        output rsp_valid,
        input  rsp_ready,
        output rsp_data,
        output rsp_err
    );
endinterface : alu_arbiter_if

// File: rtl/alu_arbiter.sv
//------------------------------------------------------------------------------
// alu_arbiter
//
// Purpose: shares one external combinational 32-bit ALU between two
// requesters. A round-robin grant picks one request in IDLE, its op and
// operands are captured, the ALU result is registered in EXEC and presented
// to the owning port in RESP until that port takes it.
//
//   handshake at cycle T -> EXEC at T+1 -> rsp_valid at T+2
//   with rsp_ready held high a new op can be accepted every 3 cycles.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   bus          alu_arbiter_if.slave: request/response handshakes
//   alu_op [3:0] op code to the external ALU (from captured register)
//   alu_a [31:0] operand A to the external ALU (from captured register)
//   alu_b [31:0] operand B to the external ALU (from captured register)
//   alu_out[31:0] ALU result, valid in the same cycle
//   busy         high whenever the FSM is not in IDLE
//
// Op codes: ADD=0 SUB=1 AND=2 OR=3 XOR=4 SRA=5 SRL=6 SLL=7 SLT=8;
// codes 9..15 are illegal and complete with rsp_err=1, rsp_data=0.
//------------------------------------------------------------------------------
module alu_arbiter (
    input  logic                clk,
    input  logic                rst_n,
    alu_arbiter_if.slave        bus,
    output logic [3:0]          alu_op,
    output logic [31:0]         alu_a,
    output logic [31:0]         alu_b,
    input  logic [31:0]         alu_out,
    output logic                busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [3:0] OP_LAST_LEGAL = 4'd8;

    state_t      state_q;
    logic [3:0]  op_q;
    logic [31:0] a_q;
    logic [31:0] b_q;
    logic        owner_q;     // port index of the op in flight
    logic        last_q;      // port index granted most recently
    logic [1:0]  rsp_valid_q;
    logic [31:0] rsp_data_q;
    logic        rsp_err_q;
    logic        busy_q;

    logic [1:0]  grant_d;
    logic        req_hs;
    logic        hs_port;
    logic        rsp_hs;

    // Codes above SLT have no defined ALU function.
    function automatic logic op_legal(input logic [3:0] op);
        return (op <= OP_LAST_LEGAL);
    endfunction

    //--------------------------------------------------------------------------
    // Round-robin grant, only offered in IDLE. On a tie the port that did
    // not win last time gets it; last_q resets to 1 so port 0 wins the first
    // tie after reset.
    //--------------------------------------------------------------------------
    always_comb begin
        grant_d = 2'b00;
        if (state_q == IDLE) begin
            case (bus.req_valid)
                2'b01:   grant_d = 2'b01;
                2'b10:   grant_d = 2'b10;
                2'b11:   grant_d = last_q ? 2'b01 : 2'b10;
                default: grant_d = 2'b00;
            endcase
        end
    end

    // The grant already implies the matching valid bit.
    assign req_hs  = |grant_d;
    assign hs_port = grant_d[1];

    // Only the owner's rsp_ready counts, and only while its rsp_valid is up,
    // which in turn is only ever the case in RESP.
    assign rsp_hs  = |(rsp_valid_q & bus.rsp_ready);

    //--------------------------------------------------------------------------
    // Control FSM with registered outputs. All capture, result and handshake
    // registers are cleared by reset so an in-flight op is simply dropped.
    //--------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            op_q        <= 4'd0;
            a_q         <= 32'd0;
            b_q         <= 32'd0;
            owner_q     <= 1'b0;
            last_q      <= 1'b1;
            rsp_valid_q <= 2'b00;
            rsp_data_q  <= 32'd0;
            rsp_err_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_hs) begin
                        op_q    <= hs_port ? bus.req_op[7:4]  : bus.req_op[3:0];
                        a_q     <= hs_port ? bus.req_a[63:32] : bus.req_a[31:0];
                        b_q     <= hs_port ? bus.req_b[63:32] : bus.req_b[31:0];
                        owner_q <= hs_port;
                        last_q  <= hs_port;
                        busy_q  <= 1'b1;
                        state_q <= EXEC;
                    end
                end

                EXEC: begin
                    // alu_out reflects the captured operands this cycle.
                    if (op_legal(op_q)) begin
                        rsp_data_q <= alu_out;
                        rsp_err_q  <= 1'b0;
                    end else begin
                        rsp_data_q <= 32'd0;
                        rsp_err_q  <= 1'b1;
                    end
                    rsp_valid_q <= owner_q ? 2'b10 : 2'b01;
                    state_q     <= RESP;
                end

                RESP: begin
                    // rsp_data is deliberately left untouched: it holds the
                    // last result after the response is taken.
                    if (rsp_hs) begin
                        rsp_valid_q <= 2'b00;
                        rsp_err_q   <= 1'b0;
                        busy_q      <= 1'b0;
                        state_q     <= IDLE;
                    end
                end

                default: begin
                    rsp_valid_q <= 2'b00;
                    rsp_err_q   <= 1'b0;
                    busy_q      <= 1'b0;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    //--------------------------------------------------------------------------
    // Outputs. The ALU is fed only from the capture registers so request
    // inputs changing in IDLE never disturb it.
    //--------------------------------------------------------------------------
    assign bus.req_ready = grant_d;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_err   = rsp_err_q;

    assign alu_op = op_q;
    assign alu_a  = a_q;
    assign alu_b  = b_q;
    assign busy   = busy_q;

endmodule : alu_arbiter

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
Parameters: none; two requesters, 32-bit data, 4-bit op fixed.
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset:
  clk        input   1   rising-edge clock for all state
  rst_n      input   1   asynchronous active-low reset
REQ-002 The block SHALL provide these request ports (port i occupies bits [i] or slice i):
  req_valid  input   2   request valid, one bit per port
  req_ready  output  2   request accepted this cycle, one bit per port
  req_op     input   8   {op1,op0}, ALU op code per port
  req_a      input   64  {a1,a0}, operand A per port
  req_b      input   64  {b1,b0}, operand B per port
REQ-003 The block SHALL provide these response ports:
  rsp_valid  output  2   result valid for port i
  rsp_ready  input   2   port i takes result
  rsp_data   output  32  result, shared by both ports
  rsp_err    output  1   op code was illegal
REQ-004 The block SHALL provide these shared-ALU ports and status:
  alu_op     output  4   op to external combinational ALU
  alu_a      output  32  operand A to ALU
  alu_b      output  32  operand B to ALU
  alu_out    input   32  ALU result, same cycle
  busy       output  1   high when state is not IDLE

Function
REQ-005 Op codes SHALL be ADD=0, SUB=1, AND=2, OR=3, XOR=4, SRA=5, SRL=6, SLL=7, SLT=8; codes 9-15 SHALL be illegal.
REQ-006 FSM states SHALL be IDLE, EXEC, RESP; IDLE->EXEC on handshake, EXEC->RESP unconditionally, RESP->IDLE on rsp_valid[owner]&rsp_ready[owner].
REQ-007 In IDLE, req_ready SHALL be the combinational grant: at most one bit high, only for a port with req_valid high; req_ready SHALL be 2'b00 in EXEC and RESP.
REQ-008 Grant SHALL be round-robin: one valid port gets the grant; both valid -> the port not granted last; the last-grant pointer updates on each handshake only.
REQ-009 On handshake (req_valid[i]&req_ready[i]) the block SHALL register op_i, a_i, b_i and owner=i.
REQ-010 alu_op/alu_a/alu_b SHALL be driven directly from the captured registers in all states (held in IDLE, no glitch from req_* inputs).
REQ-011 In EXEC the block SHALL register rsp_data=alu_out and rsp_err=0 for legal ops, or rsp_data=0 and rsp_err=1 for illegal ops.
REQ-012 In RESP, rsp_valid[owner] SHALL be 1 and the other bit 0; rsp_data and rsp_err SHALL stay stable until the handshake.
REQ-013 Latency SHALL be: handshake at cycle T -> rsp_valid at cycle T+2; minimum issue interval 3 cycles; rsp_ready held high gives back-to-back ops every 3 cycles.
REQ-014 rsp_ready for a non-owner port, and rsp_ready outside RESP, SHALL be ignored.
REQ-015 req_valid dropping in IDLE before grant SHALL have no effect; request inputs SHALL be ignored outside IDLE.
REQ-016 rsp_valid and rsp_err SHALL be 0 outside RESP; rsp_data SHALL hold its last value outside RESP.

Reset
REQ-017 On rst_n low the block SHALL asynchronously clear state to IDLE, set rsp_valid=0, rsp_err=0, rsp_data=0, set captured op/a/b=0 (alu_op/alu_a/alu_b=0), set owner=0, set last-grant pointer=1 (port 0 wins first tie), busy=0.
REQ-018 Reset during EXEC or RESP SHALL discard the in-flight op; no rsp_valid SHALL be issued for it.

Verification
REQ-019 Bench SHALL cover:
  - Reset, port0 ADD a=5 b=7 -> req_ready=2'b01 at T, rsp_valid=2'b01 at T+2, rsp_data=12, rsp_err=0.
  - Both ports valid continuously, rsp_ready=2'b11 -> grant order 0,1,0,1; each rsp_valid 3 cycles apart.
  - Port1 SUB a=3 b=5 -> rsp_data=0xFFFFFFFE; port1 SLT a=0xFFFFFFFF b=1 -> rsp_data=1.
  - rsp_ready low 5 cycles in RESP -> rsp_valid, rsp_data stable; req_ready=2'b00; busy=1.
  - Port0 op=4'hF -> rsp_err=1, rsp_data=0, then normal op accepted.
  - rst_n low during EXEC -> rsp_valid stays 0; after release, tie grants port 0 first.
